// File: rtl/react_timing_sequencer.sv
// react_timing_sequencer: event pulse generator for the reaction-test FSM.
// Turns a debounced button pulse plus the current machine state into
// one-cycle action/start/cleared/react/overflow pulses, generates the
// pseudo-random pre-start delay and measures the reaction time in ms.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   btn_pulse        debounced one-cycle button press
//   machine_state    IDLE=0 WAIT=1 CLR_CNT1=2 START=3 STORAGE=4
//                    CLR_CNT2=5 AVERAGE=6 COMPARE=7
//   signal_*         registered one-cycle event pulses
//   react_time       measured reaction time in ms (saturates at MAX_MS)
// Optional build macro FALSE_START_EN: a press during the pre-start delay
// ends it at once and forces an overflow on the following START.
module react_timing_sequencer #(
    parameter int CLK_PER_MS   = 12000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int MAX_MS       = 999
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn_pulse,
    input  logic [2:0] machine_state,
    output logic       signal_action,
    output logic       signal_start,
    output logic       signal_cleared,
    output logic       signal_react,
    output logic       signal_overflow,
    output logic [9:0] react_time
);

    localparam int PW = $clog2(CLK_PER_MS + 1);
    localparam int DW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS) + 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT     = 3'd1;
    localparam logic [2:0] ST_CLR_CNT1 = 3'd2;
    localparam logic [2:0] ST_START    = 3'd3;
    localparam logic [2:0] ST_STORAGE  = 3'd4;
    localparam logic [2:0] ST_CLR_CNT2 = 3'd5;
    localparam logic [2:0] ST_AVERAGE  = 3'd6;

    localparam logic [PW-1:0] PRE_TOP = PW'(CLK_PER_MS - 1);
    localparam logic [9:0]    RT_MAX  = 10'(MAX_MS);
    localparam logic [DW-1:0] DLY_MIN = DW'(MIN_DELAY_MS);

    typedef enum logic [1:0] {P_IDLE, P_DELAY, P_TIMING} phase_t;

    phase_t        phase_q, phase_d;
    logic [2:0]    prev_q;
    logic          fired_q, fired_d;
    logic [15:0]   lfsr_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] delay_q, delay_d;
    logic [9:0]    rt_d, rt_inc;
    logic          act_d, start_d, clr_d, react_d, ovf_d;
    logic          chg, fired_v, tick, dly_done;
`ifdef FALSE_START_EN
    logic          fs_q, fs_d;
`endif

    always_comb begin
        // A new visit starts whenever the state code differs from last cycle
        chg      = machine_state != prev_q;
        fired_v  = fired_q && !chg;
        tick     = presc_q == PRE_TOP;
        rt_inc   = (react_time >= RT_MAX) ? RT_MAX : react_time + 10'd1;
        dly_done = 1'b0;
        phase_d  = chg ? P_IDLE : phase_q;
        fired_d  = fired_v;
        presc_d  = tick ? '0 : presc_q + PW'(1);
        delay_d  = delay_q;
        rt_d     = react_time;
        act_d    = 1'b0;
        start_d  = 1'b0;
        clr_d    = 1'b0;
        react_d  = 1'b0;
        ovf_d    = 1'b0;
`ifdef FALSE_START_EN
        fs_d     = fs_q;
`endif
        case (machine_state)
            ST_IDLE, ST_STORAGE, ST_AVERAGE: begin
                if (btn_pulse && !fired_v) begin
                    act_d   = 1'b1;
                    fired_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (chg) begin
                    phase_d = P_DELAY;
                    presc_d = '0;
                    delay_d = DLY_MIN + DW'(lfsr_q[RAND_BITS-1:0]);
`ifdef FALSE_START_EN
                    fs_d    = 1'b0;
`endif
                end else if (phase_q == P_DELAY) begin
                    if (tick && delay_q != '0)
                        delay_d = delay_q - DW'(1);
                    // Last ms tick fires start directly so the pulse lands
                    // exactly delay_ms * CLK_PER_MS cycles after entry
                    dly_done = (delay_q == '0) ||
                               (tick && delay_q == DW'(1));
`ifdef FALSE_START_EN
                    if (btn_pulse) begin
                        dly_done = 1'b1;
                        fs_d     = 1'b1;
                    end
`endif
                    if (dly_done) begin
                        start_d = 1'b1;
                        fired_d = 1'b1;
                        phase_d = P_IDLE;
                    end
                end
            end
            ST_CLR_CNT1, ST_CLR_CNT2: begin
                rt_d    = '0;
                presc_d = '0;
                if (chg) begin
                    clr_d   = 1'b1;
                    fired_d = 1'b1;
                end
            end
            ST_START: begin
                if (chg) begin
                    phase_d = P_TIMING;
                    presc_d = '0;
`ifdef FALSE_START_EN
                    fs_d    = 1'b0;
                    if (fs_q) begin
                        rt_d    = RT_MAX;
                        ovf_d   = 1'b1;
                        fired_d = 1'b1;
                        phase_d = P_IDLE;
                    end
`endif
                end else if (phase_q == P_TIMING) begin
                    if (tick)
                        rt_d = rt_inc;
                    // A press on the saturating tick counts as a reaction
                    if (btn_pulse) begin
                        react_d = 1'b1;
                        fired_d = 1'b1;
                        phase_d = P_IDLE;
                    end else if (tick && rt_inc == RT_MAX) begin
                        ovf_d   = 1'b1;
                        fired_d = 1'b1;
                        phase_d = P_IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase_q         <= P_IDLE;
            prev_q          <= ST_IDLE;
            fired_q         <= 1'b0;
            lfsr_q          <= 16'hACE1;
            presc_q         <= '0;
            delay_q         <= '0;
            react_time      <= '0;
            signal_action   <= 1'b0;
            signal_start    <= 1'b0;
            signal_cleared  <= 1'b0;
            signal_react    <= 1'b0;
            signal_overflow <= 1'b0;
`ifdef FALSE_START_EN
            fs_q            <= 1'b0;
`endif
        end else begin
            phase_q         <= phase_d;
            prev_q          <= machine_state;
            fired_q         <= fired_d;
            lfsr_q          <= {lfsr_q[14:0],
                                lfsr_q[15] ^ lfsr_q[13] ^
                                lfsr_q[12] ^ lfsr_q[10]};
            presc_q         <= presc_d;
            delay_q         <= delay_d;
            react_time      <= rt_d;
            signal_action   <= act_d;
            signal_start    <= start_d;
            signal_cleared  <= clr_d;
            signal_react    <= react_d;
            signal_overflow <= ovf_d;
`ifdef FALSE_START_EN
            fs_q            <= fs_d;
`endif
        end
    end

endmodule
